insert_frame_length_header: RTL and testbench
=============================================

INSERT_FRAME_LENGTH_HEADER -- requirements
Module: insert_frame_length_header

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning stream data width in bits (multiple of 8).
REQ-002 SHALL have parameter FRAME_LENGTH_WIDTH, default 16, meaning length field width (multiple of DATA_WIDTH); H = FRAME_LENGTH_WIDTH/DATA_WIDTH header beats.
REQ-003 SHALL have parameter KEEP_WIDTH, default DATA_WIDTH/8, meaning tkeep width.
REQ-004 SHALL have one clock and an asynchronous, active-high reset: port clk  input  1  rising-edge clock.
REQ-005 port rst  input  1  asynchronous active-high reset.
REQ-006 ports s_axis_tdata/tkeep/tvalid/tready/tlast  in/in/in/out/in  DATA_WIDTH/KEEP_WIDTH/1/1/1  Ethernet frame payload in.
REQ-007 ports s_axis_frame_length_tdata/tvalid/tready  in/in/out  FRAME_LENGTH_WIDTH/1/1  one length word per frame.
REQ-008 ports m_axis_tdata/tkeep/tvalid/tready/tlast  out/out/out/in/out  DATA_WIDTH/KEEP_WIDTH/1/1/1  header-prefixed frame out.
REQ-009 port length_error  output  1  one-cycle pulse on length mismatch (see Configuration).

Function
REQ-010 SHALL implement states IDLE, HEADER, PAYLOAD.
REQ-011 IDLE: s_axis_tready=0; s_axis_frame_length_tready=1 when output register free; on length handshake latch word, clear header counter, go HEADER.
REQ-012 HEADER: emit H beats of the latched length, MSB byte first, tkeep all ones, tlast=0; after beat H accepted go PAYLOAD.
REQ-013 PAYLOAD: forward each s_axis beat unchanged (tdata, tkeep, tlast); on the beat with tlast=1 go IDLE.
REQ-014 Output SHALL be one registered stage; register loads when m_axis_tvalid=0 or m_axis_tready=1; latency input-handshake to m_axis_tvalid = 1 cycle.
REQ-015 s_axis_tready SHALL be 1 only in PAYLOAD and only when the output register can load.
REQ-016 m_axis_tdata/tkeep/tlast SHALL hold stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-017 Full throughput: back-to-back frames SHALL incur at most one idle output cycle between a tlast beat and the next header beat.
REQ-018 Frame termination SHALL be governed by s_axis_tlast only; the length value never truncates or pads the payload.
REQ-019 Length value 0 SHALL still emit H header beats of 0 followed by payload.
REQ-020 s_axis beats arriving in IDLE/HEADER SHALL be back-pressured, never dropped.
REQ-021 A length word presented while in HEADER/PAYLOAD SHALL not be consumed until IDLE.

Reset
REQ-022 On rst=1 asynchronously: state IDLE, all m_axis outputs 0, both tready outputs 0, length_error 0, counters 0.
REQ-023 Reset mid-frame SHALL discard the in-flight frame; upstream is reset together with this block.
REQ-024 First length handshake SHALL be possible on the second rising edge after rst deasserts.

Configuration
REQ-025 Macro INSERT_FRAME_LENGTH_CHECK_EN defined: count valid payload bytes (popcount of tkeep) in a FRAME_LENGTH_WIDTH counter, saturating at all ones; on tlast beat compare to latched length; pulse length_error for one cycle on mismatch, frame still forwarded.
REQ-026 Macro undefined: no counter/comparator built; length_error tied 0.

Verification
REQ-027 Length 60, 60-byte payload, sink always ready -> output 0x00,0x3C then 60 bytes, tlast on byte 62, length_error=0.
REQ-028 Length 64, payload 64 bytes, m_axis_tready toggling 50% random -> byte-identical output, no stall-induced data change.
REQ-029 Two frames (length 0x05DC and 0x0040) back-to-back, lengths queued early -> headers 0x05,0xDC and 0x00,0x40 in order, each before its payload.
REQ-030 Payload valid before length valid (length at cycle 30) -> s_axis_tready=0 until header emitted, no beat lost.
REQ-031 With check enabled, length 100 and 98-byte payload -> length_error pulse 1 cycle at tlast; without macro -> length_error stays 0.
REQ-032 rst asserted after header + 10 payload bytes -> outputs 0 same cycle; fresh frame after release forwarded correctly.

Source files
------------

// File: rtl/insert_frame_length_header.sv
// Prefixes each frame with its FRAME_LENGTH_WIDTH length word (MSB byte first) through one output register.
// Optional INSERT_FRAME_LENGTH_CHECK_EN: compares the payload byte count with the length and pulses length_error.
module insert_frame_length_header #(
    parameter int DATA_WIDTH         = 8,
    parameter int FRAME_LENGTH_WIDTH = 16,
    parameter int KEEP_WIDTH         = DATA_WIDTH/8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]         s_axis_tkeep,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic                          s_axis_tlast,
    input  logic [FRAME_LENGTH_WIDTH-1:0] s_axis_frame_length_tdata,
    input  logic                          s_axis_frame_length_tvalid,
    output logic                          s_axis_frame_length_tready,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic                          length_error
);
    localparam int H  = FRAME_LENGTH_WIDTH / DATA_WIDTH;
    localparam int CW = (H > 1) ? $clog2(H) : 1;

    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD} state_t;

    state_t                        state_q, state_d;
    logic [FRAME_LENGTH_WIDTH-1:0] len_q, len_d;
    logic [CW-1:0]                 hdr_cnt_q, hdr_cnt_d;
    logic                          started_q;
    logic [DATA_WIDTH-1:0]         tdata_q, tdata_d;
    logic [KEEP_WIDTH-1:0]         tkeep_q, tkeep_d;
    logic                          tvalid_q, tvalid_d;
    logic                          tlast_q, tlast_d;
    logic                          load;
    logic                          len_hs;
    logic                          pay_hs;
    logic [FRAME_LENGTH_WIDTH-1:0] hdr_shift;

    assign load                       = !tvalid_q || m_axis_tready;
    // started_q holds off the first length handshake until the second edge after reset release
    assign s_axis_frame_length_tready = started_q && (state_q == IDLE) && load;
    assign s_axis_tready              = (state_q == PAYLOAD) && load;
    assign len_hs                     = s_axis_frame_length_tvalid && s_axis_frame_length_tready;
    assign pay_hs                     = s_axis_tvalid && s_axis_tready;
    assign hdr_shift                  = len_q >> (DATA_WIDTH * (H - 1 - int'(hdr_cnt_q)));

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tkeep  = tkeep_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        hdr_cnt_d = hdr_cnt_q;
        tdata_d   = tdata_q;
        tkeep_d   = tkeep_q;
        tlast_d   = tlast_q;
        tvalid_d  = load ? 1'b0 : tvalid_q;
        case (state_q)
            IDLE: begin
                if (len_hs) begin
                    len_d     = s_axis_frame_length_tdata;
                    hdr_cnt_d = '0;
                    state_d   = HEADER;
                end
            end
            HEADER: begin
                if (load) begin
                    tdata_d  = hdr_shift[DATA_WIDTH-1:0];
                    tkeep_d  = '1;
                    tlast_d  = 1'b0;
                    tvalid_d = 1'b1;
                    if (hdr_cnt_q == CW'(H - 1)) state_d = PAYLOAD;
                    else                         hdr_cnt_d = hdr_cnt_q + 1'b1;
                end
            end
            PAYLOAD: begin
                if (pay_hs) begin
                    tdata_d  = s_axis_tdata;
                    tkeep_d  = s_axis_tkeep;
                    tlast_d  = s_axis_tlast;
                    tvalid_d = 1'b1;
                    if (s_axis_tlast) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            len_q     <= '0;
            hdr_cnt_q <= '0;
            started_q <= 1'b0;
            tdata_q   <= '0;
            tkeep_q   <= '0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            hdr_cnt_q <= hdr_cnt_d;
            started_q <= 1'b1;
            tdata_q   <= tdata_d;
            tkeep_q   <= tkeep_d;
            tvalid_q  <= tvalid_d;
            tlast_q   <= tlast_d;
        end
    end

`ifdef INSERT_FRAME_LENGTH_CHECK_EN
    logic [FRAME_LENGTH_WIDTH-1:0] byte_cnt_q, byte_cnt_d;
    logic                          err_q, err_d;
    logic [FRAME_LENGTH_WIDTH:0]   sum;
    logic [FRAME_LENGTH_WIDTH-1:0] sat;

    function automatic logic [FRAME_LENGTH_WIDTH:0] popcnt(input logic [KEEP_WIDTH-1:0] k);
        logic [FRAME_LENGTH_WIDTH:0] c;
        c = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) c = c + {{FRAME_LENGTH_WIDTH{1'b0}}, k[i]};
        return c;
    endfunction

    assign sum = {1'b0, byte_cnt_q} + popcnt(s_axis_tkeep);
    assign sat = sum[FRAME_LENGTH_WIDTH] ? '1 : sum[FRAME_LENGTH_WIDTH-1:0];

    always_comb begin
        byte_cnt_d = byte_cnt_q;
        err_d      = 1'b0;
        if (len_hs) byte_cnt_d = '0;
        if (pay_hs) begin
            byte_cnt_d = sat;
            if (s_axis_tlast) err_d = (sat != len_q);
        end
    end

    // error registers alongside the tlast beat so both appear on the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            err_q      <= err_d;
        end
    end

    assign length_error = err_q;
`else
    assign length_error = 1'b0;
`endif
endmodule

// File: tb/tb_insert_frame_length_header.sv
// Randomized bench for insert_frame_length_header: frames are expanded into an expected byte stream
// (length header then payload) and compared beat by beat at the output handshake.
module tb_insert_frame_length_header;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  s_tdata = '0;
    logic [0:0]  s_tkeep = 1'b1;
    logic        s_tvalid = 1'b0, s_tready, s_tlast = 1'b0;
    logic [15:0] l_tdata = '0;
    logic        l_tvalid = 1'b0, l_tready;
    logic [7:0]  m_tdata;
    logic [0:0]  m_tkeep;
    logic        m_tvalid, m_tlast, length_error;
    logic        m_tready = 1'b1;

    insert_frame_length_header dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
        .s_axis_frame_length_tdata(l_tdata), .s_axis_frame_length_tvalid(l_tvalid),
        .s_axis_frame_length_tready(l_tready),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .length_error(length_error)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;
    logic [8:0]  src_q[$];
    logic [15:0] len_q[$];
    logic [9:0]  exp_q[$];
    int cyc = 0, len_gate = 0, lens_taken = 0, frames_sent = 0, out_cnt = 0;
    int err_seen = 0, exp_err = 0;
    bit sink_rand = 0, src_rand = 0, prev_stall = 0, prev_err = 0;
    logic [9:0] prev_beat = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push_frame(input int len, input int n);
        logic [15:0] l16;
        logic [7:0]  d;
        l16 = len[15:0];
        len_q.push_back(l16);
        exp_q.push_back({1'b0, 1'b1, l16[15:8]});
        exp_q.push_back({1'b0, 1'b1, l16[7:0]});
        for (int i = 0; i < n; i++) begin
            d = 8'($urandom);
            src_q.push_back({(i == n - 1), d});
            exp_q.push_back({(i == n - 1), 1'b1, d});
        end
        if (len != n) exp_err++;
    endtask

    task automatic step();
        logic [9:0] e;
        @(negedge clk);
        if (prev_stall) chk("hold", {m_tlast, m_tkeep, m_tdata}, prev_beat);
        if (cyc < len_gate) chk("bp_before_len", s_tready, 0);
        if (s_tready) chk("rdy_order", (lens_taken > frames_sent), 1);
        if (m_tvalid && m_tready) begin
            out_cnt++;
            if (exp_q.size() == 0) chk("spurious", 1, 0);
            else begin
                e = exp_q.pop_front();
                chk("data", m_tdata, e[7:0]);
                chk("keep", m_tkeep, e[8]);
                chk("last", m_tlast, e[9]);
            end
        end
        prev_stall = m_tvalid && !m_tready;
        prev_beat  = {m_tlast, m_tkeep, m_tdata};
        if (length_error) begin
            err_seen++;
            chk("err_width", prev_err, 0);
        end
        prev_err = length_error;
        if (s_tvalid && s_tready) begin
            if (src_q[0][8]) frames_sent++;
            void'(src_q.pop_front());
        end
        if (l_tvalid && l_tready) begin
            void'(len_q.pop_front());
            lens_taken++;
        end
        @(posedge clk); #1;
        cyc++;
        m_tready = sink_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        s_tvalid = (src_q.size() > 0) && (!src_rand || $urandom_range(0, 3) != 0);
        {s_tlast, s_tdata} = (src_q.size() > 0) ? src_q[0] : 9'h0;
        l_tvalid = (len_q.size() > 0) && (cyc >= len_gate);
        l_tdata  = (len_q.size() > 0) ? len_q[0] : 16'h0;
    endtask

    task automatic run(input string tag);
        int k;
        k = 0;
        while ((src_q.size() || len_q.size() || exp_q.size()) && k < 8000) begin
            step();
            k++;
        end
        if (k >= 8000) chk({tag, "_timeout"}, 1, 0);
        for (int i = 0; i < 4; i++) step();
`ifdef INSERT_FRAME_LENGTH_CHECK_EN
        chk({tag, "_len_err"}, err_seen, exp_err);
`else
        chk({tag, "_len_err"}, err_seen, 0);
`endif
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_mvalid"}, m_tvalid, 0);
        chk({tag, "_mdata"}, m_tdata, 0);
        chk({tag, "_mkeep"}, m_tkeep, 0);
        chk({tag, "_mlast"}, m_tlast, 0);
        chk({tag, "_srdy"}, s_tready, 0);
        chk({tag, "_lrdy"}, l_tready, 0);
        chk({tag, "_lerr"}, length_error, 0);
    endtask

    initial begin
        #1;
        chk_outputs_zero("reset");
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk); chk("lrdy_edge1", l_tready, 0);
        @(negedge clk); chk("lrdy_edge2", l_tready, 1);
        @(posedge clk); #1;

        // 60-byte frame, sink always ready
        push_frame(60, 60);
        run("f60");
        // 64-byte frame against a randomly stalling sink
        sink_rand = 1;
        push_frame(64, 64);
        run("f64_stall");
        // two frames with both lengths queued up front
        sink_rand = 0; src_rand = 1;
        push_frame(16'h05DC, 1500);
        push_frame(16'h0040, 64);
        run("two_frames");
        // payload presented long before its length word
        len_gate = cyc + 30;
        push_frame(20, 20);
        run("late_len");
        len_gate = 0;
        // length mismatch and zero length
        push_frame(100, 98);
        run("mismatch");
        sink_rand = 1;
        push_frame(0, 5);
        run("zero_len");
        // random frames
        for (int f = 0; f < 4; f++) begin
            int n;
            n = $urandom_range(1, 30);
            push_frame(($urandom_range(0, 3) == 0) ? n + 1 : n, n);
        end
        run("random");

        // reset after header + 10 payload bytes
        sink_rand = 0; src_rand = 0;
        out_cnt = 0;
        push_frame(40, 40);
        for (int k = 0; k < 500 && out_cnt < 12; k++) step();
        chk("pre_reset_cnt", out_cnt, 12);
        rst = 1'b1;
        #1;
        chk_outputs_zero("midrst");
        src_q.delete(); len_q.delete(); exp_q.delete();
        s_tvalid = 0; l_tvalid = 0;
        lens_taken = 0; frames_sent = 0; prev_stall = 0; prev_err = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        push_frame(30, 30);
        run("after_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
